axis_operand_packer: RTL and testbench
======================================

AXIS_OPERAND_PACKER -- requirements
Module: axis_operand_packer

Interface
REQ-001 Parameter ELEM_W, default 4, operand element width in bits; legal range 1..8.
REQ-002 Parameter LANE_W, default 8, byte-lane pitch of the packed output word; fixed at 8.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tvalid  input  1  upstream element beat valid.
REQ-006 s_axis_tdata  input  8  one element in bits [ELEM_W-1:0]; upper bits ignored.
REQ-007 s_axis_tlast  input  1  last element of packet.
REQ-008 s_axis_tready  output  1  packer accepts a beat this cycle.
REQ-009 m_axis_tvalid  output  1  packed operand word valid.
REQ-010 m_axis_tdata  output  32  packed word {b1,b0,a1,a0}, one element per byte lane.
REQ-011 m_axis_tlast  output  1  word closes the input packet.
REQ-012 m_axis_tready  input  1  downstream (2x2 matmul stage) accepts the word.
REQ-013 short_pkt  output  1  one-cycle pulse: packet ended with fewer than 4 beats in the final word.

Function
REQ-014 Input beat is accepted when s_axis_tvalid && s_axis_tready; output word transfers when m_axis_tvalid && m_axis_tready.
REQ-015 A 2-bit lane counter selects the assembly lane: 0->a0 (bits 7:0), 1->a1 (15:8), 2->b0 (23:16), 3->b1 (31:24).
REQ-016 Each accepted element is written zero-extended: lane bits [ELEM_W-1:0] = s_axis_tdata[ELEM_W-1:0], remaining lane bits 0.
REQ-017 The word completes on the accepted beat with lane==3 or with s_axis_tlast==1, whichever comes first.
REQ-018 On completion, the assembled word (with the current beat merged, unfilled lanes 0) loads the output register the next cycle; m_axis_tvalid rises one cycle after the completing beat.
REQ-019 m_axis_tlast of that word equals s_axis_tlast of the completing beat.
REQ-020 short_pkt pulses high for the cycle m_axis_tvalid first rises for a word completed by tlast at lane 0, 1 or 2.
REQ-021 After completion the lane counter and assembly register clear to 0; the next packet starts at a0.
REQ-022 s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational from m_axis_tready; single output register, no skid).
REQ-023 This is a two-state FSM: IDLE (output register empty) and HOLD (output register full). IDLE->HOLD on a completing beat. HOLD->IDLE on transfer with no completing beat in the same cycle. HOLD stays HOLD on transfer plus a simultaneous completing beat, and the register reloads.
REQ-024 While m_axis_tvalid && !m_axis_tready, m_axis_tdata, m_axis_tlast and m_axis_tvalid hold stable; no input beat is accepted.
REQ-025 Sustained throughput with m_axis_tready held high is one input beat per cycle, i.e. one output word per 4 cycles.
REQ-026 A beat with tlast at lane 3 behaves as a full word: m_axis_tlast=1 and short_pkt stays 0.

Reset
REQ-027 When rst is high at a clock edge: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, short_pkt=0, lane counter=0, assembly register=0, FSM=IDLE.
REQ-028 Reset mid-packet discards partial assembly and any pending output word without emitting it.
REQ-029 s_axis_tready is 1 in the first cycle after reset.

Structure
REQ-030 Shared package mpu_axis_pkg holds LANE_W, the lane-count constant (4), lane index constants (A0=0, A1=1, B0=2, B1=3) and the FSM state typedef.
REQ-031 The block is a single flat module with no sub-module; the output register is inline.

Verification
REQ-032 Reset, then beats 0x3,0x5,0x7,0x9 (tlast on the 4th) with m_axis_tready=1 -> one word 0x09070503 with m_axis_tlast=1 one cycle after the 4th beat; short_pkt=0.
REQ-033 Beats 0xF1,0x02 with tlast on the 2nd -> word 0x00000201, m_axis_tlast=1, short_pkt pulses once.
REQ-034 8 back-to-back beats 1..8 (tlast on the 8th) with m_axis_tready=1 -> words 0x04030201 (tlast=0) then 0x08070605 (tlast=1); s_axis_tready stays 1 throughout.
REQ-035 First word complete, m_axis_tready=0 for 5 cycles -> s_axis_tready=0, output held stable, no beat lost; on release, words are produced in order.
REQ-036 rst asserted after 2 beats of a packet, then beats 0xA,0xB,0xC,0xD (tlast on the 4th) -> only 0x0D0C0B0A is emitted.
REQ-037 Completing beat in the same cycle as output transfer -> register reloads, m_axis_tvalid stays 1, no bubble and no duplicate.

Source files
------------

// File: rtl/mpu_axis_pkg.sv
// ---------------------------------------------------------------------------
// mpu_axis_pkg
// Shared definitions for the matmul-unit AXI-Stream front end.
//   LANE_W         byte-lane pitch of packed operand words
//   NUM_LANES      element lanes per packed word (a0, a1, b0, b1)
//   LANE_A0..B1    lane index encodings used by the assembly counter
//   pack_state_e   output-register occupancy state
// ---------------------------------------------------------------------------
package mpu_axis_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] LANE_A0 = 2'd0;
  localparam logic [1:0] LANE_A1 = 2'd1;
  localparam logic [1:0] LANE_B0 = 2'd2;
  localparam logic [1:0] LANE_B1 = 2'd3;

  // IDLE: output register empty, HOLD: output register carries a word
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/axis_operand_packer.sv
// ---------------------------------------------------------------------------
// axis_operand_packer
// Packs a stream of narrow operand elements into 32-bit words laid out as
// {b1, b0, a1, a0}, one zero-extended element per byte lane, for the 2x2
// matmul stage. A word closes after four elements or on tlast, whichever is
// first; unfilled lanes of a short word are zero.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   s_axis_tvalid  upstream element valid
//   s_axis_tdata   element in bits [ELEM_W-1:0], upper bits ignored
//   s_axis_tlast   last element of packet
//   s_axis_tready  packer accepts an element this cycle
//   m_axis_tvalid  packed word valid
//   m_axis_tdata   packed word {b1, b0, a1, a0}
//   m_axis_tlast   word closes the input packet
//   m_axis_tready  downstream accepts the word
//   short_pkt      one-cycle pulse when a word was closed early by tlast
// ---------------------------------------------------------------------------
module axis_operand_packer #(
  parameter int ELEM_W = 4,
  parameter int LANE_W = mpu_axis_pkg::LANE_W
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      s_axis_tvalid,
  input  logic [7:0]                                s_axis_tdata,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic                                      m_axis_tvalid,
  output logic [mpu_axis_pkg::NUM_LANES*LANE_W-1:0] m_axis_tdata,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic                                      short_pkt
);

  import mpu_axis_pkg::*;

  localparam int WORD_W = NUM_LANES * LANE_W;

  pack_state_e       state_q, state_d;
  logic [1:0]        lane_q;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] merged;
  logic [LANE_W-1:0] elem_ext;
  logic [WORD_W-1:0] data_q;
  logic              last_q;
  logic              short_q;
  logic              accept;
  logic              complete;
  logic              xfer;
  logic              unused_tdata;

  // Only the low ELEM_W bits of each element carry data.
  assign unused_tdata = ^s_axis_tdata;

  // Single output register with no skid: upstream may only push when the
  // register is empty or is being drained in this very cycle.
  assign m_axis_tvalid = (state_q == ST_HOLD);
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign xfer          = m_axis_tvalid && m_axis_tready;
  assign complete      = accept && ((lane_q == LANE_B1) || s_axis_tlast);

  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;
  assign short_pkt     = short_q;

  // Current beat merged into the partial word so a completing beat can be
  // loaded straight into the output register.
  always_comb begin
    elem_ext = '0;
    elem_ext[ELEM_W-1:0] = s_axis_tdata[ELEM_W-1:0];
    merged = asm_q;
    case (lane_q)
      LANE_A0: merged[0*LANE_W +: LANE_W] = elem_ext;
      LANE_A1: merged[1*LANE_W +: LANE_W] = elem_ext;
      LANE_B0: merged[2*LANE_W +: LANE_W] = elem_ext;
      LANE_B1: merged[3*LANE_W +: LANE_W] = elem_ext;
      default: merged = asm_q;
    endcase
  end

  // Occupancy next-state; a completing beat while draining keeps HOLD so the
  // register reloads without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (complete) state_d = ST_HOLD;
      ST_HOLD: begin
        if (complete)  state_d = ST_HOLD;
        else if (xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Assembly and output register. short_pkt is a single-cycle flag marking
  // the first cycle a tlast-truncated word is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= LANE_A0;
      asm_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      short_q <= 1'b0;
      if (complete) begin
        data_q  <= merged;
        last_q  <= s_axis_tlast;
        short_q <= s_axis_tlast && (lane_q != LANE_B1);
        lane_q  <= LANE_A0;
        asm_q   <= '0;
      end else if (accept) begin
        asm_q  <= merged;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_operand_packer.sv
// ---------------------------------------------------------------------------
// tb_axis_operand_packer
// Directed bench for axis_operand_packer with ELEM_W = 4. Inputs change 1 ns
// after the rising edge; a monitor captures transferred words and short_pkt
// pulses on the falling edge.
// ---------------------------------------------------------------------------
module tb_axis_operand_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        short_pkt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [32:0] words[$];
  int          short_cnt = 0;
  logic        ready_watch = 1'b0;
  logic        ready_dropped = 1'b0;

  axis_operand_packer #(.ELEM_W(4), .LANE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .short_pkt     (short_pkt)
  );

  always #5 clk = ~clk;

  // Inputs are stable from 1 ns after a rising edge, so what is seen here is
  // what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) words.push_back({m_axis_tlast, m_axis_tdata});
      if (short_pkt) short_cnt++;
      if (ready_watch && !s_axis_tready) ready_dropped = 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] pop_word();
    if (words.size() == 0) return 'x;
    return words.pop_front();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one element and returns 1 ns after the edge that accepted it.
  task automatic apply_stimulus(input logic [7:0] d, input logic l);
    logic acc;
    int   waited;
    acc    = 1'b0;
    waited = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis_tready;
      step();
      if (!acc) begin
        waited++;
        if (waited > 50) begin
          tests_run++;
          tests_failed++;
          $error("FAIL beat_accept_timeout observed=stalled expected=accepted");
          break;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check_output("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_output("rst_tdata",  64'(m_axis_tdata),  64'd0);
    check_output("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check_output("rst_short",  64'(short_pkt),     64'd0);
    check_output("rst_sready", 64'(s_axis_tready), 64'd1);
    step();
    rst = 1'b0;
    check_output("post_rst_sready", 64'(s_axis_tready), 64'd1);

    // Full word, tlast on lane b1
    apply_stimulus(8'h03, 1'b0);
    apply_stimulus(8'h05, 1'b0);
    apply_stimulus(8'h07, 1'b0);
    check_output("full_not_yet_valid", 64'(m_axis_tvalid), 64'd0);
    apply_stimulus(8'h09, 1'b1);
    check_output("full_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_output("full_tdata",  64'(m_axis_tdata),  64'h09070503);
    check_output("full_tlast",  64'(m_axis_tlast),  64'd1);
    check_output("full_short",  64'(short_pkt),     64'd0);
    repeat (3) step();
    check_output("full_count",      64'(words.size()), 64'd1);
    check_output("full_word",       64'(pop_word()),   {31'd0, 1'b1, 32'h09070503});
    check_output("full_short_cnt",  64'(short_cnt),    64'd0);
    check_output("full_idle_after", 64'(m_axis_tvalid), 64'd0);

    // Short packet, upper element bits ignored
    short_cnt = 0;
    apply_stimulus(8'hF1, 1'b0);
    apply_stimulus(8'h02, 1'b1);
    check_output("short_tdata", 64'(m_axis_tdata), 64'h00000201);
    check_output("short_tlast", 64'(m_axis_tlast), 64'd1);
    check_output("short_pulse", 64'(short_pkt),    64'd1);
    repeat (3) step();
    check_output("short_count",     64'(words.size()), 64'd1);
    check_output("short_word",      64'(pop_word()),   {31'd0, 1'b1, 32'h00000201});
    check_output("short_pulse_cnt", 64'(short_cnt),    64'd1);

    // Eight back-to-back beats
    ready_watch = 1'b1;
    for (int i = 1; i <= 8; i++) apply_stimulus(8'(i), i == 8);
    repeat (3) step();
    ready_watch = 1'b0;
    check_output("b2b_sready_dropped", 64'(ready_dropped), 64'd0);
    check_output("b2b_count", 64'(words.size()), 64'd2);
    check_output("b2b_word0", 64'(pop_word()), {31'd0, 1'b0, 32'h04030201});
    check_output("b2b_word1", 64'(pop_word()), {31'd0, 1'b1, 32'h08070605});

    // Backpressure: word held while m_axis_tready is low
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i), 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h05;
    s_axis_tlast  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("bp_sready", 64'(s_axis_tready), 64'd0);
      check_output("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
      check_output("bp_tdata",  64'(m_axis_tdata),  64'h04030201);
      check_output("bp_tlast",  64'(m_axis_tlast),  64'd0);
      step();
    end
    m_axis_tready = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    apply_stimulus(8'h06, 1'b0);
    apply_stimulus(8'h07, 1'b0);
    apply_stimulus(8'h08, 1'b1);
    repeat (3) step();
    check_output("bp_count", 64'(words.size()), 64'd2);
    check_output("bp_word0", 64'(pop_word()), {31'd0, 1'b0, 32'h04030201});
    check_output("bp_word1", 64'(pop_word()), {31'd0, 1'b1, 32'h08070605});

    // Completing beat in the same cycle as the output transfer
    apply_stimulus(8'h03, 1'b1);
    check_output("reload_first", 64'(m_axis_tdata), 64'h00000003);
    apply_stimulus(8'h04, 1'b1);
    check_output("reload_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_output("reload_tdata",  64'(m_axis_tdata),  64'h00000004);
    repeat (3) step();
    check_output("reload_count", 64'(words.size()), 64'd2);
    check_output("reload_word0", 64'(pop_word()), {31'd0, 1'b1, 32'h00000003});
    check_output("reload_word1", 64'(pop_word()), {31'd0, 1'b1, 32'h00000004});

    // Reset mid-packet discards the partial word
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    apply_stimulus(8'h0A, 1'b0);
    apply_stimulus(8'h0B, 1'b0);
    apply_stimulus(8'h0C, 1'b0);
    apply_stimulus(8'h0D, 1'b1);
    check_output("midrst_tdata", 64'(m_axis_tdata), 64'h0D0C0B0A);
    repeat (3) step();
    check_output("midrst_count", 64'(words.size()), 64'd1);
    check_output("midrst_word",  64'(pop_word()), {31'd0, 1'b1, 32'h0D0C0B0A});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
